// File: rtl/rv32_pkg.sv
// Shared RV32I memory-access definitions: funct3 width codes, LSU state
// encoding and the load/store legality check also used by the decoder.
package rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } lsu_state_t;

    // Unsigned loads only exist for loads; halfwords need even, words need 4-byte alignment.
    function automatic logic mem_access_legal(input logic       is_store,
                                              input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
        logic legal;
        case (funct3)
            F3_B:    legal = 1'b1;
            F3_H:    legal = ~addr_lo[0];
            F3_W:    legal = (addr_lo == 2'b00);
            F3_BU:   legal = ~is_store;
            F3_HU:   legal = ~is_store & ~addr_lo[0];
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store data replication / byte enables and
// load byte/halfword extraction with sign or zero extension.
module lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_lane_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be        = 4'b0000;
        st_lane_data = st_wdata;
        case (st_funct3)
            F3_B, F3_BU: begin
                st_be        = 4'b0001 << st_addr_lo;
                st_lane_data = {4{st_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                st_be        = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lane_data = {2{st_wdata[15:0]}};
            end
            F3_W:    st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    always_comb begin
        case (ld_addr_lo)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_port.sv
// Load/store unit: accepts one access at a time, runs the req/gnt/rvalid
// handshake with data memory and reports done, misaligned or bus timeout.
module lsu_dmem_port
    import rv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       DataOut,
    output logic              done,
    output logic              busy,
    output logic              misaligned,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_q, state_d;
    logic [7:0]  wait_cnt;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_addr_lo;
    logic        accept, legal, rsp_done, rsp_timeout;
    logic [3:0]  st_be;
    logic [31:0] st_lane_data, ld_data;

    assign accept      = req_valid && (state_q == IDLE);
    assign legal       = mem_access_legal(is_store, funct3, addr[1:0]);
    assign rsp_done    = (state_q == WAIT_RSP) && mem_rvalid;
    // A response arriving on the final allowed cycle beats the timeout.
    assign rsp_timeout = (state_q == WAIT_RSP) && !mem_rvalid && (wait_cnt == WAIT_LIMIT);

    lsu_align u_align (
        .st_funct3    (funct3),
        .st_addr_lo   (addr[1:0]),
        .st_wdata     (wdata),
        .st_be        (st_be),
        .st_lane_data (st_lane_data),
        .ld_funct3    (lat_funct3),
        .ld_addr_lo   (lat_addr_lo),
        .ld_rdata     (mem_rdata),
        .ld_data      (ld_data)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        busy      = 1'b1;
        mem_req   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (accept && legal) state_d = REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rsp_done || rsp_timeout) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           wait_cnt <= 8'd0;
        else if (state_q == REQ && mem_gnt)   wait_cnt <= 8'd0;
        else if (state_q == WAIT_RSP)         wait_cnt <= wait_cnt + 8'd1;
    end

    // Request fields are captured on every accept, legal or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_funct3  <= 3'd0;
            lat_addr_lo <= 2'd0;
            mem_we      <= 1'b0;
            mem_be      <= 4'd0;
            mem_addr    <= '0;
            mem_wdata   <= 32'd0;
        end else if (accept) begin
            lat_funct3  <= funct3;
            lat_addr_lo <= addr[1:0];
            mem_we      <= is_store;
            mem_be      <= st_be;
            mem_addr    <= {addr[ADDR_W-1:2], 2'b00};
            mem_wdata   <= st_lane_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            DataOut    <= 32'd0;
        end else begin
            done       <= rsp_done;
            misaligned <= accept && !legal;
            bus_err    <= rsp_timeout;
            if (rsp_done && !mem_we) DataOut <= ld_data;
        end
    end

endmodule

// File: doc/lsu_dmem_port.md
Name: lsu_dmem_port

Overview:
Load/store unit between the ALU result/rs2 operands and data memory. It produces the DataOut word consumed by the writeback select, where MemtoReg chooses between the ALU result and DataOut. It accepts one load/store request at a time and runs a req/gnt/rvalid handshake with the data memory. It aligns store data into byte lanes, extracts and sign/zero-extends load data, and flags misaligned accesses and bus timeouts. The core stalls on busy.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles in WAIT_RSP before bus_err is raised (legal range 2..255).
ADDR_W, 32, address width.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  control requests a load/store this cycle
req_ready  out  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high
is_store  in  1  1 = store, 0 = load
funct3  in  3  RV32I width/sign code
addr  in  ADDR_W  effective address (ALU result)
wdata  in  32  store data (rs2)
DataOut  out  32  formatted load result (registered)
done  out  1  one-cycle pulse when the access completes
busy  out  1  state != IDLE; core stall
misaligned  out  1  one-cycle pulse; access rejected
bus_err  out  1  one-cycle pulse; response timeout
mem_req  out  1  memory request
mem_we  out  1  write enable
mem_be  out  4  byte enables
mem_addr  out  ADDR_W  word address; bits [1:0] are always 0
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted by memory
mem_rvalid  in  1  response valid (read data or write ack)
mem_rdata  in  32  read data

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except req_ready=1; DataOut=0; timeout counter=0. Takes effect immediately, including mid-transaction: mem_req drops with no glitch back to 1.
- FSM: IDLE -> REQ -> WAIT_RSP -> IDLE.
- IDLE:
  - On accept, latch is_store, funct3, addr[1:0], mem_addr={addr[31:2],2'b00}, mem_be, mem_wdata.
  - If the access is legal, go to REQ.
  - If illegal, pulse misaligned next cycle, stay in IDLE, and make no memory access.
  - Illegal means: halfword with addr[0]=1; word with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
- REQ:
  - mem_req=1 with stable addr/we/be/wdata until mem_gnt.
  - On gnt, go to WAIT_RSP and clear the counter.
  - No timeout in REQ.
- WAIT_RSP:
  - mem_req=0; the counter increments each cycle.
  - On mem_rvalid: for a load, register DataOut=format(mem_rdata). Then pulse done and go to IDLE.
  - If the counter reaches TIMEOUT_CYCLES without rvalid: pulse bus_err, go to IDLE, leave DataOut unchanged.
  - rvalid in the same cycle the limit is reached wins: the access completes normally.
- mem_rvalid or mem_gnt arriving in IDLE is ignored. A stale response after reset or timeout is dropped.
- Store lanes:
  - SB: be=1<<addr[1:0], wdata={4{b}}.
  - SH: be=4'b0011 if addr[1]=0, else 4'b1100; wdata={2{h}}.
  - SW: be=4'b1111.
- Load extract: select byte/halfword by the latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- DataOut holds its value across stores, errors and idle cycles.
- Minimum latency: accept at T0, mem_req at T1, gnt at T1, rvalid at T2, done and DataOut valid at T3.
- done, misaligned and bus_err are mutually exclusive. Each is at most one cycle wide.

Decomposition:
- Shared package rv32_pkg:
  - funct3 localparams F3_B/H/W/BU/HU;
  - LSU state encoding (IDLE=2'd0, REQ=2'd1, WAIT_RSP=2'd2);
  - a legality check function shared with the decoder.
- One combinational sub-module, lsu_align: store lane/byte-enable generation and load extract/extend. The FSM and counter live in the top.

Test Plan:
- LW addr 0x100, gnt at T1, rvalid at T2 with rdata 0xDEADBEEF -> done at T3, DataOut=0xDEADBEEF, mem_addr=0x100, be=1111, we=0.
- LB addr 0x103, rdata 0x80FF1234 -> DataOut=0xFFFFFF80. Repeat as LBU -> 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SH addr 0x102, wdata 0x0000ABCD -> mem_addr=0x100, be=1100, mem_wdata=0xABCDABCD, we=1. After rvalid: done pulse, DataOut unchanged.
- LW addr 0x101 -> misaligned pulse at T1, mem_req never asserted, busy stays 0, DataOut unchanged.
- TIMEOUT_CYCLES=4, gnt given, no rvalid -> bus_err pulses 4 cycles after WAIT_RSP entry, return to IDLE. A late rvalid is ignored and done stays 0.
- rst_n low while in REQ (gnt held low) -> mem_req and busy go to 0 asynchronously. After release, req_ready=1 and DataOut=0.
